// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: state encoding and counter widths.
package pll_seq_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned RETRY_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_FILTER    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   // Retry counter increment, holding at all-ones.
   function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
      return (v == '1) ? v : v + RETRY_W'(1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchroniser; both stages clear to 0 on synchronous reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_seq.sv
// Camera PLL supervisor: resets the PLL, filters LOCK, releases camera reset, retries and faults.
// Optional lock-loss counter output loss_cnt_o is built when PLL_LOCK_LOSS_CNT_EN is defined.
module pll_lock_seq
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYC     = 64,
   parameter int unsigned LOCK_FILT_CYC    = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
   parameter int unsigned MAX_RETRY        = 4,
   parameter int unsigned CNT_W            = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_lock_i,
   input  logic               relock_req_i,
   output logic               pll_reset_o,
   output logic               cam_rst_o,
   output logic               ready_o,
   output logic               fault_o,
   output logic [RETRY_W-1:0] retry_cnt_o,
   output logic [STATE_W-1:0] state_o
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,output logic [7:0]         loss_cnt_o
`endif
);

   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0]   FILT_LAST    = CNT_W'(LOCK_FILT_CYC - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

   logic               w_lock_s;
   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [RETRY_W-1:0] r_retry;
   logic [RETRY_W-1:0] w_retry_nxt;
   logic [RETRY_W-1:0] w_retry_inc;
   logic               w_fail;
   logic               r_pll_reset;
   logic               r_cam_rst;
   logic               r_ready;
   logic               r_fault;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .i_d (pll_lock_i),
      .o_q (w_lock_s)
   );

   assign w_retry_inc = retry_sat_inc(r_retry);

   // Next state, retry count and cycle counter.
   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry;
      w_fail      = 1'b0;
      case (r_state)
         S_RESET:     if (r_cnt == HOLD_LAST) w_state_nxt = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            if (w_lock_s)                     w_state_nxt = S_FILTER;
            else if (r_cnt == TIMEOUT_LAST)   w_fail      = 1'b1;
         end
         S_FILTER: begin
            if (!w_lock_s) begin
               w_fail = 1'b1;
            end else if (r_cnt == FILT_LAST) begin
               w_state_nxt = S_RUN;
               w_retry_nxt = '0;
            end
         end
         S_RUN:       if (!w_lock_s) w_state_nxt = S_RESET;
         S_FAULT:     w_state_nxt = S_FAULT;
         default:     w_state_nxt = S_RESET;
      endcase

      if (w_fail) begin
         w_retry_nxt = w_retry_inc;
         w_state_nxt = (w_retry_inc >= RETRY_LIMIT) ? S_FAULT : S_RESET;
      end

      // A relock request overrides every other transition this cycle.
      if (relock_req_i) begin
         w_state_nxt = S_RESET;
         w_retry_nxt = '0;
      end

      if ((w_state_nxt != r_state) || relock_req_i) w_cnt_nxt = '0;
      else if (r_cnt == '1)                         w_cnt_nxt = r_cnt;
      else                                          w_cnt_nxt = r_cnt + CNT_W'(1);
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_RESET;
         r_cnt       <= '0;
         r_retry     <= '0;
         r_pll_reset <= 1'b1;
         r_cam_rst   <= 1'b1;
         r_ready     <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_retry     <= w_retry_nxt;
         r_pll_reset <= (w_state_nxt == S_RESET) || (w_state_nxt == S_FAULT);
         r_cam_rst   <= (w_state_nxt != S_RUN);
         r_ready     <= (w_state_nxt == S_RUN);
         r_fault     <= (w_state_nxt == S_FAULT);
      end
   end

   assign pll_reset_o = r_pll_reset;
   assign cam_rst_o   = r_cam_rst;
   assign ready_o     = r_ready;
   assign fault_o     = r_fault;
   assign retry_cnt_o = r_retry;
   assign state_o     = STATE_W'(r_state);

`ifdef PLL_LOCK_LOSS_CNT_EN
   logic [7:0] r_loss_cnt;

   // Counts only genuine lock losses from S_RUN; a relock request is not a loss.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_loss_cnt <= 8'd0;
      end else if ((r_state == S_RUN) && !w_lock_s && !relock_req_i && (r_loss_cnt != 8'hFF)) begin
         r_loss_cnt <= r_loss_cnt + 8'd1;
      end
   end

   assign loss_cnt_o = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed self-checking bench for pll_lock_seq with short cycle parameters.
module tb_pll_lock_seq;

   localparam logic [2:0] ST_RESET  = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_FILTER = 3'd2;
   localparam logic [2:0] ST_RUN    = 3'd3;
   localparam logic [2:0] ST_FAULT  = 3'd4;

   logic       clk;
   logic       rst;
   logic       pll_lock_i;
   logic       relock_req_i;
   logic       pll_reset_o;
   logic       cam_rst_o;
   logic       ready_o;
   logic       fault_o;
   logic [2:0] retry_cnt_o;
   logic [2:0] state_o;
`ifdef PLL_LOCK_LOSS_CNT_EN
   logic [7:0] loss_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   // {state, pll_reset, cam_rst, ready, fault, retry}
   logic [9:0] obs;
   assign obs = {state_o, pll_reset_o, cam_rst_o, ready_o, fault_o, retry_cnt_o};

   pll_lock_seq #(
      .RST_HOLD_CYC     (4),
      .LOCK_FILT_CYC    (8),
      .LOCK_TIMEOUT_CYC (20),
      .MAX_RETRY        (2),
      .CNT_W            (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_lock_i   (pll_lock_i),
      .relock_req_i (relock_req_i),
      .pll_reset_o  (pll_reset_o),
      .cam_rst_o    (cam_rst_o),
      .ready_o      (ready_o),
      .fault_o      (fault_o),
      .retry_cnt_o  (retry_cnt_o),
      .state_o      (state_o)
`ifdef PLL_LOCK_LOSS_CNT_EN
     ,.loss_cnt_o   (loss_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [9:0] ev(input logic [2:0] st, input logic pr, input logic cr,
                                     input logic rd, input logic ft, input logic [2:0] rc);
      return {st, pr, cr, rd, ft, rc};
   endfunction

   // Advance n rising edges; inputs change and outputs are sampled 1 time unit after each edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic lock);
      pll_lock_i = lock;
      rst        = 1'b1;
      tick(3);
      rst        = 1'b0;
   endtask

   task automatic test_reset;
      relock_req_i = 1'b0;
      do_reset(1'b1);
      checks++; if (obs !== ev(ST_RESET, 1, 1, 0, 0, 0)) begin errors++; $display("FAIL reset_values: got %b exp %b", obs, ev(ST_RESET, 1, 1, 0, 0, 0)); end
   endtask

   // Sync fill overlaps the reset hold, so RUN arrives 4+1+8 = 13 edges after rst release.
   task automatic test_nominal;
      tick(3);
      checks++; if (obs !== ev(ST_RESET, 1, 1, 0, 0, 0)) begin errors++; $display("FAIL nom_hold_edge3: got %b exp %b", obs, ev(ST_RESET, 1, 1, 0, 0, 0)); end
      tick(1);
      checks++; if (obs !== ev(ST_WAIT, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL nom_wait_edge4: got %b exp %b", obs, ev(ST_WAIT, 0, 1, 0, 0, 0)); end
      tick(1);
      checks++; if (obs !== ev(ST_FILTER, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL nom_filter_edge5: got %b exp %b", obs, ev(ST_FILTER, 0, 1, 0, 0, 0)); end
      tick(7);
      checks++; if (obs !== ev(ST_FILTER, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL nom_filter_edge12: got %b exp %b", obs, ev(ST_FILTER, 0, 1, 0, 0, 0)); end
      tick(1);
      checks++; if (obs !== ev(ST_RUN, 0, 0, 1, 0, 0)) begin errors++; $display("FAIL nom_run_edge13: got %b exp %b", obs, ev(ST_RUN, 0, 0, 1, 0, 0)); end
   endtask

   task automatic test_filter_glitch;
      do_reset(1'b1);
      tick(7);
      pll_lock_i = 1'b0;
      tick(1);
      pll_lock_i = 1'b1;
      tick(1);
      checks++; if (obs !== ev(ST_FILTER, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL glitch_pre: got %b exp %b", obs, ev(ST_FILTER, 0, 1, 0, 0, 0)); end
      tick(1);
      checks++; if (obs !== ev(ST_RESET, 1, 1, 0, 0, 1)) begin errors++; $display("FAIL glitch_fail: got %b exp %b", obs, ev(ST_RESET, 1, 1, 0, 0, 1)); end
      tick(12);
      checks++; if (obs !== ev(ST_FILTER, 0, 1, 0, 0, 1)) begin errors++; $display("FAIL glitch_refilter: got %b exp %b", obs, ev(ST_FILTER, 0, 1, 0, 0, 1)); end
      tick(1);
      checks++; if (obs !== ev(ST_RUN, 0, 0, 1, 0, 0)) begin errors++; $display("FAIL glitch_run: got %b exp %b", obs, ev(ST_RUN, 0, 0, 1, 0, 0)); end
   endtask

   task automatic test_timeout_fault;
      do_reset(1'b0);
      tick(24);
      checks++; if (obs !== ev(ST_RESET, 1, 1, 0, 0, 1)) begin errors++; $display("FAIL timeout1: got %b exp %b", obs, ev(ST_RESET, 1, 1, 0, 0, 1)); end
      tick(23);
      checks++; if (obs !== ev(ST_WAIT, 0, 1, 0, 0, 1)) begin errors++; $display("FAIL timeout2_wait: got %b exp %b", obs, ev(ST_WAIT, 0, 1, 0, 0, 1)); end
      tick(1);
      checks++; if (obs !== ev(ST_FAULT, 1, 1, 0, 1, 2)) begin errors++; $display("FAIL fault_entry: got %b exp %b", obs, ev(ST_FAULT, 1, 1, 0, 1, 2)); end
      tick(100);
      checks++; if (obs !== ev(ST_FAULT, 1, 1, 0, 1, 2)) begin errors++; $display("FAIL fault_sticky: got %b exp %b", obs, ev(ST_FAULT, 1, 1, 0, 1, 2)); end
   endtask

   task automatic test_relock_priority;
      pll_lock_i   = 1'b1;
      relock_req_i = 1'b1;
      tick(1);
      relock_req_i = 1'b0;
      checks++; if (obs !== ev(ST_RESET, 1, 1, 0, 0, 0)) begin errors++; $display("FAIL relock_exit: got %b exp %b", obs, ev(ST_RESET, 1, 1, 0, 0, 0)); end
      tick(12);
      checks++; if (obs !== ev(ST_FILTER, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL relock_filter: got %b exp %b", obs, ev(ST_FILTER, 0, 1, 0, 0, 0)); end
      tick(1);
      checks++; if (obs !== ev(ST_RUN, 0, 0, 1, 0, 0)) begin errors++; $display("FAIL relock_run: got %b exp %b", obs, ev(ST_RUN, 0, 0, 1, 0, 0)); end
   endtask

   task automatic test_lock_loss;
      pll_lock_i = 1'b0;
      tick(2);
      checks++; if (obs !== ev(ST_RUN, 0, 0, 1, 0, 0)) begin errors++; $display("FAIL loss_edge2: got %b exp %b", obs, ev(ST_RUN, 0, 0, 1, 0, 0)); end
      tick(1);
      checks++; if (obs !== ev(ST_RESET, 1, 1, 0, 0, 0)) begin errors++; $display("FAIL loss_edge3: got %b exp %b", obs, ev(ST_RESET, 1, 1, 0, 0, 0)); end
`ifdef PLL_LOCK_LOSS_CNT_EN
      checks++; if (loss_cnt_o !== 8'd1) begin errors++; $display("FAIL loss_cnt: got %0d exp 1", loss_cnt_o); end
`endif
   endtask

   task automatic test_reset_mid_filter;
      do_reset(1'b1);
      tick(7);
      pll_lock_i = 1'b0;
      tick(1);
      pll_lock_i = 1'b1;
      tick(12);
      checks++; if (obs !== ev(ST_FILTER, 0, 1, 0, 0, 1)) begin errors++; $display("FAIL mid_filter_pre: got %b exp %b", obs, ev(ST_FILTER, 0, 1, 0, 0, 1)); end
      rst = 1'b1;
      tick(1);
      checks++; if (obs !== ev(ST_RESET, 1, 1, 0, 0, 0)) begin errors++; $display("FAIL mid_filter_rst: got %b exp %b", obs, ev(ST_RESET, 1, 1, 0, 0, 0)); end
`ifdef PLL_LOCK_LOSS_CNT_EN
      checks++; if (loss_cnt_o !== 8'd0) begin errors++; $display("FAIL loss_cnt_rst: got %0d exp 0", loss_cnt_o); end
`endif
      rst = 1'b0;
      tick(12);
      checks++; if (obs !== ev(ST_FILTER, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL restart_filter: got %b exp %b", obs, ev(ST_FILTER, 0, 1, 0, 0, 0)); end
      tick(1);
      checks++; if (obs !== ev(ST_RUN, 0, 0, 1, 0, 0)) begin errors++; $display("FAIL restart_run: got %b exp %b", obs, ev(ST_RUN, 0, 0, 1, 0, 0)); end
   endtask

   initial begin
      rst          = 1'b1;
      pll_lock_i   = 1'b0;
      relock_req_i = 1'b0;
      test_reset;
      test_nominal;
      test_filter_glitch;
      test_timeout_fault;
      test_relock_priority;
      test_lock_loss;
      test_reset_mid_filter;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
